// File: rtl/logic_lut_pkg.sv
// Shared types and width helpers for the programmable truth-table bank.
package logic_lut_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 10;
  localparam int TBL_W     = 2 ** N_IN_DEF;
  localparam int SEL_W     = $clog2(N_OUT_DEF);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // A single-function bank still needs a one-bit select port.
  function automatic int sel_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/logic_lut_bank_slice.sv
// One programmable output function: a truth-table register and its index mux.
module lut_slice
  import logic_lut_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_we,
  input  logic [(2**N_IN)-1:0]   i_data,
  input  logic [N_IN-1:0]        i_idx,
  output logic                   o_bit
);

  logic [(2**N_IN)-1:0] r_table;

  // Table storage, rewritten whole on a selected config strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_table <= '0;
    end else if (i_we) begin
      r_table <= i_data;
    end
  end

  assign o_bit = r_table[i_idx];

endmodule

// File: rtl/logic_lut_bank.sv
// Bank of N_OUT programmable N_IN-input functions with handshake evaluation
// and a hardware sweep that streams every input combination.
module logic_lut_bank
  import logic_lut_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [sel_width(N_OUT)-1:0]   cfg_sel,
  input  logic [(2**N_IN)-1:0]          cfg_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_IN-1:0]               in_vec,
  input  logic                          sweep_start,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_IN-1:0]               out_idx,
  output logic [N_OUT-1:0]              out_vec
);

  localparam int TW = 2 ** N_IN;
  localparam int SW = sel_width(N_OUT);
  localparam int CW = N_IN + 1;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_out_valid;
  logic [N_IN-1:0]    r_out_idx;
  logic [N_OUT-1:0]   r_out_vec;

  logic               w_slot_free;
  logic               w_in_ready;
  logic               w_load;
  logic               w_last;
  logic [N_IN-1:0]    w_idx;
  logic [N_OUT-1:0]   w_bits;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_in_ready  = (r_state == ST_IDLE) && !sweep_start && w_slot_free;
  assign w_load      = (r_state == ST_SWEEP) ? w_slot_free : (in_valid && w_in_ready);
  assign w_idx       = (r_state == ST_SWEEP) ? r_cnt[N_IN-1:0] : in_vec;
  assign w_last      = (r_cnt == CW'(TW - 1));

  // Out-of-range selects match no slice, so such writes fall away naturally.
  for (genvar k = 0; k < N_OUT; k++) begin : g_slice
    lut_slice #(.N_IN(N_IN)) u_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_we   (cfg_we && (cfg_sel == SW'(k))),
      .i_data (cfg_data),
      .i_idx  (w_idx),
      .o_bit  (w_bits[k])
    );
  end

  // Sweep FSM and the single-entry result slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_vec   <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= w_idx;
        r_out_vec   <= w_bits;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (sweep_start) begin
            r_state <= ST_SWEEP;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_SWEEP: begin
          if (w_slot_free) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_vec   = r_out_vec;

endmodule

// File: tb/tb_logic_lut_bank.sv
// Self-checking bench for logic_lut_bank: directed table, sweep sequences,
// reset abort and randomized traffic against a queue-based reference model.
module tb_logic_lut_bank;

  localparam int N_IN  = 4;
  localparam int N_OUT = 10;
  localparam int TW    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [3:0]        cfg_sel;
  logic [TW-1:0]     cfg_data;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_vec;
  logic              sweep_start;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [N_IN-1:0]   out_idx;
  logic [N_OUT-1:0]  out_vec;

  logic_lut_bank #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .sweep_start(sweep_start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_vec(out_vec)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [TW-1:0]    m_tbl [N_OUT];
  logic             m_valid;
  logic [N_IN-1:0]  m_idx;
  logic [N_OUT-1:0] m_vec;
  int               sweep_q [$];
  int               got_idx [$];
  logic             got_v0  [$];

  typedef struct {
    logic          we;
    logic [3:0]    sel;
    logic [TW-1:0] data;
    logic          iv;
    logic [3:0]    vec;
    logic          e_valid;
    logic [3:0]    e_idx;
    logic          e_v0;
  } row_t;

  row_t rows [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_OUT; k++) m_tbl[k] = '0;
    m_valid = 1'b0;
    m_idx   = '0;
    m_vec   = '0;
    sweep_q.delete();
  endtask

  task automatic clear_inputs();
    cfg_we      = 1'b0;
    cfg_sel     = 4'd0;
    cfg_data    = 16'h0000;
    in_valid    = 1'b0;
    in_vec      = 4'd0;
    sweep_start = 1'b0;
    out_ready   = 1'b1;
  endtask

  // One clock: predict from the currently driven inputs, then compare after the edge.
  task automatic step();
    logic             free;
    logic             exp_rdy;
    logic             ld;
    logic [N_IN-1:0]  idx;
    logic [N_OUT-1:0] v;
    #2;
    free    = !m_valid || out_ready;
    exp_rdy = (sweep_q.size() == 0) && !sweep_start && free;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (out_valid && out_ready) begin
      got_idx.push_back(int'(out_idx));
      got_v0.push_back(out_vec[0]);
    end
    ld  = 1'b0;
    idx = '0;
    if (sweep_q.size() != 0) begin
      if (free) begin
        ld  = 1'b1;
        idx = 4'(sweep_q.pop_front());
      end
    end else if (sweep_start) begin
      for (int i = 0; i < TW; i++) sweep_q.push_back(i);
    end else if (in_valid && exp_rdy) begin
      ld  = 1'b1;
      idx = in_vec;
    end
    v = '0;
    for (int k = 0; k < N_OUT; k++) v[k] = m_tbl[k][idx];
    if (ld) begin
      m_valid = 1'b1;
      m_idx   = idx;
      m_vec   = v;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (cfg_we && (int'(cfg_sel) < N_OUT)) m_tbl[cfg_sel] = cfg_data;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_idx",   32'(out_idx),   32'(m_idx));
    chk("out_vec",   32'(out_vec),   32'(m_vec));
    chk("busy",      32'(busy),      32'(sweep_q.size() != 0));
  endtask

  task automatic run_sweep(input logic [3:0] pat, input logic with_iv);
    logic [TW-1:0] ref_f0;
    ref_f0 = 16'h6F62;
    clear_inputs();
    step();
    got_idx.delete();
    got_v0.delete();
    sweep_start = 1'b1;
    in_valid    = with_iv;
    in_vec      = 4'd5;
    step();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    for (int i = 0; (i < 80) && (got_idx.size() < TW); i++) begin
      out_ready = pat[i % 4];
      step();
    end
    chk("sweep_count", 32'(got_idx.size()), 32'(TW));
    for (int i = 0; (i < got_idx.size()) && (i < TW); i++) begin
      chk($sformatf("sweep_idx%0d", i), 32'(got_idx[i]), 32'(i));
      chk($sformatf("sweep_f0_%0d", i), 32'(got_v0[i]), 32'(ref_f0[i]));
    end
  endtask

  initial begin
    rows[0] = '{1'b1, 4'd0,  16'h6F62, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    rows[1] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd9, 1'b1, 4'd9, 1'b1};
    rows[2] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd7, 1'b1, 4'd7, 1'b0};
    rows[3] = '{1'b1, 4'd0,  16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0};
    rows[4] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1};
    rows[5] = '{1'b1, 4'd12, 16'h0000, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1};
    rows[6] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1};
    rows[7] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1};
    rows[8] = '{1'b1, 4'd0,  16'h6F62, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1};

    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_idx",   32'(out_idx),   32'd0);
    chk("rst_vec",   32'(out_vec),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cfg_we      = rows[i].we;
      cfg_sel     = rows[i].sel;
      cfg_data    = rows[i].data;
      in_valid    = rows[i].iv;
      in_vec      = rows[i].vec;
      sweep_start = 1'b0;
      out_ready   = 1'b1;
      step();
      chk($sformatf("row%0d_valid", i), 32'(out_valid),  32'(rows[i].e_valid));
      chk($sformatf("row%0d_idx", i),   32'(out_idx),    32'(rows[i].e_idx));
      chk($sformatf("row%0d_f0", i),    32'(out_vec[0]), 32'(rows[i].e_v0));
    end

    run_sweep(4'b1111, 1'b0);
    run_sweep(4'b1001, 1'b0);
    run_sweep(4'b1111, 1'b1);

    clear_inputs();
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid && (out_idx == 4'd7)) break;
      step();
    end
    chk("abort_at_idx7", 32'(out_idx), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_vec",   32'(out_vec),   32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 4'd9;
    step();
    chk("post_rst_vec", 32'(out_vec), 32'd0);

    for (int i = 0; i < 400; i++) begin
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_sel     = 4'($urandom_range(0, 15));
      cfg_data    = 16'($urandom);
      in_valid    = 1'($urandom_range(0, 1));
      in_vec      = 4'($urandom);
      sweep_start = ($urandom_range(0, 24) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
